// File: rtl/uma_arbiter8_if.sv
// Bus between the UMA masters and the eight-way arbiter: requests, completion
// and enable go in; the registered grant, debug pointer and watchdog pulse come out.
interface uma_arbiter8_if;
  logic       enable_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;
  logic [2:0] ptr;

  modport master (
    output enable_n, req, done,
    input  grant, grant_id, grant_valid, timeout, ptr
  );

  modport slave (
    input  enable_n, req, done,
    output grant, grant_id, grant_valid, timeout, ptr
  );
endinterface

// File: rtl/uma_arbiter8.sv
// Eight-requester arbiter for the shared UMA port: round-robin or fixed priority,
// grant held until done/withdraw/watchdog, then one mandatory idle turnaround cycle.
module uma_arbiter8 #(
  parameter int          ROUND_ROBIN = 1,
  parameter int unsigned MAX_HOLD    = 1024
) (
  input logic            clk,
  input logic            rst_n,
  uma_arbiter8_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam bit          WD_EN      = (MAX_HOLD != 0);
  localparam logic [15:0] HOLD_LIMIT = WD_EN ? 16'(MAX_HOLD - 1) : 16'd0;

  state_t      state_reg, state_next;
  logic [7:0]  grant_reg, grant_next;
  logic [2:0]  grant_id_reg, grant_id_next;
  logic        grant_valid_reg, grant_valid_next;
  logic        timeout_reg, timeout_next;
  logic [2:0]  ptr_reg, ptr_next;
  logic [15:0] hold_reg, hold_next;

  logic [2:0]  scan_base;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic [2:0]  win_id;
  logic        wd_expire;
  logic        owner_req;

  // Fixed-priority mode always scans from index 0.
  assign scan_base = (ROUND_ROBIN != 0) ? ptr_reg : 3'd0;

  // Rotate requests so that bit 0 is the current highest-priority master.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      localparam logic [2:0] OFF = 3'(gi);
      assign req_rot[gi] = bus.req[scan_base + OFF];
    end
  endgenerate

  always_comb begin
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
  end

  assign win_id    = scan_base + win_off;
  assign owner_req = bus.req[grant_id_reg];
  assign wd_expire = WD_EN && (hold_reg == HOLD_LIMIT);

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    grant_id_next    = grant_id_reg;
    grant_valid_next = grant_valid_reg;
    timeout_next     = 1'b0;
    ptr_next         = ptr_reg;
    hold_next        = hold_reg;

    case (state_reg)
      IDLE: begin
        if (!bus.enable_n && (|bus.req)) begin
          state_next       = OWN;
          grant_next       = 8'd1 << win_id;
          grant_id_next    = win_id;
          grant_valid_next = 1'b1;
          hold_next        = 16'd0;
        end
      end

      OWN: begin
        hold_next = (hold_reg == 16'hFFFF) ? hold_reg : hold_reg + 16'd1;
        if (bus.done || !owner_req || wd_expire) begin
          state_next       = RELEASE;
          grant_next       = 8'd0;
          grant_id_next    = 3'd0;
          grant_valid_next = 1'b0;
          hold_next        = 16'd0;
          // Watchdog only reports when neither done nor a withdraw explains the exit.
          timeout_next     = !bus.done && owner_req && wd_expire;
          if (ROUND_ROBIN != 0) begin
            ptr_next = grant_id_reg + 3'd1;
          end
        end
      end

      RELEASE: begin
        state_next = IDLE;
      end

      default: begin
        state_next       = IDLE;
        grant_next       = 8'd0;
        grant_id_next    = 3'd0;
        grant_valid_next = 1'b0;
        hold_next        = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= 8'd0;
      grant_id_reg    <= 3'd0;
      grant_valid_reg <= 1'b0;
      timeout_reg     <= 1'b0;
      ptr_reg         <= 3'd0;
      hold_reg        <= 16'd0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      grant_id_reg    <= grant_id_next;
      grant_valid_reg <= grant_valid_next;
      timeout_reg     <= timeout_next;
      ptr_reg         <= ptr_next;
      hold_reg        <= hold_next;
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_id    = grant_id_reg;
  assign bus.grant_valid = grant_valid_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.ptr         = ptr_reg;

endmodule

// File: tb/tb_uma_arbiter8.sv
// Directed bench for uma_arbiter8: round-robin, fixed-priority and watchdog instances,
// each observed as {grant, grant_id, grant_valid, timeout, ptr} against hand-computed values.
module tb_uma_arbiter8;
  logic clk;
  logic rst_n;
  int   pass_count;
  int   check_count;

  uma_arbiter8_if rr_if ();
  uma_arbiter8_if fp_if ();
  uma_arbiter8_if wd_if ();

  uma_arbiter8 #(.ROUND_ROBIN(1), .MAX_HOLD(1024)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(rr_if)
  );
  uma_arbiter8 #(.ROUND_ROBIN(0), .MAX_HOLD(1024)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(fp_if)
  );
  uma_arbiter8 #(.ROUND_ROBIN(1), .MAX_HOLD(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .bus(wd_if)
  );

  // Observation word: grant[15:8], grant_id[7:5], grant_valid[4], timeout[3], ptr[2:0].
  logic [15:0] rr_obs, fp_obs, wd_obs;
  assign rr_obs = {rr_if.grant, rr_if.grant_id, rr_if.grant_valid, rr_if.timeout, rr_if.ptr};
  assign fp_obs = {fp_if.grant, fp_if.grant_id, fp_if.grant_valid, fp_if.timeout, fp_if.ptr};
  assign wd_obs = {wd_if.grant, wd_if.grant_id, wd_if.grant_valid, wd_if.timeout, wd_if.ptr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rr_if.enable_n = 1'b0; rr_if.req = 8'h00; rr_if.done = 1'b0;
    fp_if.enable_n = 1'b0; fp_if.req = 8'h00; fp_if.done = 1'b0;
    wd_if.enable_n = 1'b0; wd_if.req = 8'h00; wd_if.done = 1'b0;
    tick();
    tick();
    check_count++;
    if (rr_obs !== 16'h0000) $display("FAIL reset_rr: got %h expected %h", rr_obs, 16'h0000);
    else pass_count++;
    check_count++;
    if (fp_obs !== 16'h0000) $display("FAIL reset_fp: got %h expected %h", fp_obs, 16'h0000);
    else pass_count++;
    check_count++;
    if (wd_obs !== 16'h0000) $display("FAIL reset_wd: got %h expected %h", wd_obs, 16'h0000);
    else pass_count++;
    rst_n = 1'b1;
    $display("reset: rr=%h fp=%h wd=%h", rr_obs, fp_obs, wd_obs);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_count++;
      if (rr_obs !== 16'h0000) $display("FAIL idle_cycle%0d: got %h expected %h", i, rr_obs, 16'h0000);
      else pass_count++;
      $display("idle cycle %0d: obs=%h", i, rr_obs);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp;
    rr_if.req = 8'b1001_0100;
    tick();
    exp = {8'b0000_0100, 3'd2, 1'b1, 1'b0, 3'd0};
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_grant_id2: got %h expected %h", rr_obs, exp);
    else pass_count++;
    // Requests changing during ownership must not disturb the grant.
    rr_if.req = 8'b1001_1100;
    tick();
    tick();
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_hold_id2: got %h expected %h", rr_obs, exp);
    else pass_count++;
    rr_if.req = 8'b1001_0100;
    rr_if.done = 1'b1;
    tick();
    rr_if.done = 1'b0;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd3};
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_release_ptr3: got %h expected %h", rr_obs, exp);
    else pass_count++;
    tick();
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_turnaround_ptr3: got %h expected %h", rr_obs, exp);
    else pass_count++;
    tick();
    exp = {8'b0001_0000, 3'd4, 1'b1, 1'b0, 3'd3};
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_grant_id4: got %h expected %h", rr_obs, exp);
    else pass_count++;
    $display("rr: grant id4 obs=%h", rr_obs);
    rr_if.done = 1'b1;
    tick();
    rr_if.done = 1'b0;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd5};
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_release_ptr5: got %h expected %h", rr_obs, exp);
    else pass_count++;
    tick();
    tick();
    exp = {8'b1000_0000, 3'd7, 1'b1, 1'b0, 3'd5};
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_grant_id7: got %h expected %h", rr_obs, exp);
    else pass_count++;
    $display("rr: grant id7 obs=%h", rr_obs);
    rr_if.done = 1'b1;
    tick();
    rr_if.done = 1'b0;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd0};
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_wrap_ptr0: got %h expected %h", rr_obs, exp);
    else pass_count++;
    tick();
    tick();
    exp = {8'b0000_0100, 3'd2, 1'b1, 1'b0, 3'd0};
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_regrant_id2: got %h expected %h", rr_obs, exp);
    else pass_count++;
    $display("rr: regrant id2 obs=%h", rr_obs);
    rr_if.req = 8'h00;
    rr_if.done = 1'b1;
    tick();
    rr_if.done = 1'b0;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd3};
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_final_release: got %h expected %h", rr_obs, exp);
    else pass_count++;
    tick();
    tick();
    check_count++;
    if (rr_obs !== exp) $display("FAIL rr_idle_after: got %h expected %h", rr_obs, exp);
    else pass_count++;
  endtask

  task automatic test_enable();
    logic [15:0] exp;
    rr_if.enable_n = 1'b1;
    rr_if.req = 8'hFF;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd3};
    for (int i = 0; i < 3; i++) begin
      tick();
      check_count++;
      if (rr_obs !== exp) $display("FAIL enable_blocked%0d: got %h expected %h", i, rr_obs, exp);
      else pass_count++;
    end
    rr_if.enable_n = 1'b0;
    tick();
    exp = {8'b0000_1000, 3'd3, 1'b1, 1'b0, 3'd3};
    check_count++;
    if (rr_obs !== exp) $display("FAIL enable_grant_id3: got %h expected %h", rr_obs, exp);
    else pass_count++;
    $display("enable: grant id3 obs=%h", rr_obs);
    rr_if.enable_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_count++;
      if (rr_obs !== exp) $display("FAIL enable_hold%0d: got %h expected %h", i, rr_obs, exp);
      else pass_count++;
    end
    rr_if.done = 1'b1;
    tick();
    rr_if.done = 1'b0;
    rr_if.req = 8'h00;
    rr_if.enable_n = 1'b0;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd4};
    check_count++;
    if (rr_obs !== exp) $display("FAIL enable_release_ptr4: got %h expected %h", rr_obs, exp);
    else pass_count++;
    tick();
    tick();
  endtask

  task automatic test_done_withdraw();
    logic [15:0] exp;
    rr_if.req = 8'b0000_0010;
    tick();
    exp = {8'b0000_0010, 3'd1, 1'b1, 1'b0, 3'd4};
    check_count++;
    if (rr_obs !== exp) $display("FAIL dw_grant_id1: got %h expected %h", rr_obs, exp);
    else pass_count++;
    rr_if.req = 8'h00;
    rr_if.done = 1'b1;
    tick();
    rr_if.done = 1'b0;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd2};
    for (int i = 0; i < 3; i++) begin
      check_count++;
      if (rr_obs !== exp) $display("FAIL dw_release%0d: got %h expected %h", i, rr_obs, exp);
      else pass_count++;
      $display("done+withdraw cycle %0d: obs=%h", i, rr_obs);
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    logic [15:0] exp_own;
    logic [15:0] exp_rel;
    exp_own = {8'b0000_0001, 3'd0, 1'b1, 1'b0, 3'd0};
    exp_rel = 16'h0000;
    fp_if.req = 8'b1000_0001;
    tick();
    check_count++;
    if (fp_obs !== exp_own) $display("FAIL fp_first_grant: got %h expected %h", fp_obs, exp_own);
    else pass_count++;
    for (int i = 0; i < 3; i++) begin
      fp_if.done = 1'b1;
      tick();
      fp_if.done = 1'b0;
      check_count++;
      if (fp_obs !== exp_rel) $display("FAIL fp_release%0d: got %h expected %h", i, fp_obs, exp_rel);
      else pass_count++;
      tick();
      tick();
      check_count++;
      if (fp_obs !== exp_own) $display("FAIL fp_regrant%0d: got %h expected %h", i, fp_obs, exp_own);
      else pass_count++;
      $display("fixed: pulse %0d obs=%h", i, fp_obs);
    end
    fp_if.req = 8'h00;
    tick();
    check_count++;
    if (fp_obs !== exp_rel) $display("FAIL fp_withdraw: got %h expected %h", fp_obs, exp_rel);
    else pass_count++;
    tick();
  endtask

  task automatic test_watchdog();
    logic [15:0] exp;
    wd_if.req = 8'b0010_0000;
    exp = {8'b0010_0000, 3'd5, 1'b1, 1'b0, 3'd0};
    for (int i = 0; i < 4; i++) begin
      tick();
      check_count++;
      if (wd_obs !== exp) $display("FAIL wd_own%0d: got %h expected %h", i, wd_obs, exp);
      else pass_count++;
    end
    tick();
    exp = {8'h00, 3'd0, 1'b0, 1'b1, 3'd6};
    check_count++;
    if (wd_obs !== exp) $display("FAIL wd_timeout: got %h expected %h", wd_obs, exp);
    else pass_count++;
    $display("watchdog: forced release obs=%h", wd_obs);
    tick();
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd6};
    check_count++;
    if (wd_obs !== exp) $display("FAIL wd_timeout_pulse: got %h expected %h", wd_obs, exp);
    else pass_count++;
    tick();
    exp = {8'b0010_0000, 3'd5, 1'b1, 1'b0, 3'd6};
    check_count++;
    if (wd_obs !== exp) $display("FAIL wd_regrant: got %h expected %h", wd_obs, exp);
    else pass_count++;
    wd_if.req = 8'h00;
    tick();
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 3'd6};
    check_count++;
    if (wd_obs !== exp) $display("FAIL wd_withdraw: got %h expected %h", wd_obs, exp);
    else pass_count++;
  endtask

  task automatic test_async_reset();
    logic [15:0] exp;
    rr_if.req = 8'b1000_0001;
    tick();
    exp = {8'b1000_0000, 3'd7, 1'b1, 1'b0, 3'd2};
    check_count++;
    if (rr_obs !== exp) $display("FAIL ar_grant_id7: got %h expected %h", rr_obs, exp);
    else pass_count++;
    #3;
    rst_n = 1'b0;
    #1;
    check_count++;
    if (rr_obs !== 16'h0000) $display("FAIL ar_async_drop: got %h expected %h", rr_obs, 16'h0000);
    else pass_count++;
    $display("async reset mid-own: obs=%h", rr_obs);
    #1;
    rst_n = 1'b1;
    tick();
    exp = {8'b0000_0001, 3'd0, 1'b1, 1'b0, 3'd0};
    check_count++;
    if (rr_obs !== exp) $display("FAIL ar_restart_ptr0: got %h expected %h", rr_obs, exp);
    else pass_count++;
    rr_if.req = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    pass_count = 0;
    check_count = 0;
    test_reset();
    test_idle();
    test_round_robin();
    test_enable();
    test_done_withdraw();
    test_fixed_priority();
    test_watchdog();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
